// File: rtl/i2c_pkg.sv
// Shared state encoding and bus-level constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and turns them into registered edge and START/STOP pulses.
// Every pulse appears 3 clk after the pin change; sda_level is aligned with scl_rise.
module i2c_bus_monitor (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_level
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;

  // Sync stages reset to the idle-high bus level so leaving reset makes no edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_hist  <= 1'b1;
      sda_level <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], scl_i};
      sda_sync  <= {sda_sync[0], sda_i};
      scl_hist  <= scl_sync[1];
      sda_level <= sda_sync[1];
      scl_rise  <= scl_sync[1] & ~scl_hist;
      scl_fall  <= ~scl_sync[1] & scl_hist;
      start_det <= scl_sync[1] & scl_hist & sda_level & ~sda_sync[1];
      stop_det  <= scl_sync[1] & scl_hist & ~sda_level & sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target serving a byte-wide register file with an auto-incrementing pointer.
// SDA_HOLD_CLKS must be at least 2.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h50,
  parameter int         NREGS         = 16,
  parameter int         SDA_HOLD_CLKS = 4,
  parameter int         PTR_W         = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_reg,
  output logic [7:0]       wr_data,
  output logic             rd_nack,
  input  logic [PTR_W-1:0] host_raddr,
  output logic [7:0]       host_rdata
);

  localparam int HOLD_W = $clog2(SDA_HOLD_CLKS);

  logic scl_rise, scl_fall, start_det, stop_det, sda_level;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_level (sda_level)
  );

  i2c_tgt_state_t    state;
  logic [7:0]        shift;
  logic [3:0]        bit_cnt;
  logic [PTR_W-1:0]  ptr;
  logic              rw;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pend_oe;
  logic [7:0]        regs [NREGS];
  logic [7:0]        byte_in;

  assign byte_in    = {shift[6:0], sda_level};
  assign host_rdata = regs[host_raddr];

  // A drive change decided at an SCL fall is parked in pend_oe and applied
  // when hold_cnt expires, so SDA only moves well inside the SCL low phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      rd_nack  <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      ptr      <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      rw       <= 1'b0;
      hold_cnt <= '0;
      pend_oe  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      rd_nack  <= 1'b0;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HOLD_W'(1)) sda_oe <= pend_oe;
      end
      if (stop_det) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          ADDR, REG, WDATA: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7 && state == REG) ptr <= byte_in[PTR_W-1:0];
            if (bit_cnt == 4'd7 && state == WDATA) begin
              regs[ptr] <= byte_in;
              wr_valid  <= 1'b1;
              wr_reg    <= ptr;
              wr_data   <= byte_in;
              ptr       <= ptr + 1'b1;
            end
          end
          RDATA: bit_cnt <= bit_cnt + 1'b1;
          RDATA_ACK: begin
            ptr <= ptr + 1'b1;
            if (sda_level == I2C_NACK) begin
              rd_nack <= 1'b1;
              busy    <= 1'b0;
              state   <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (shift[7:1] == DEV_ADDR) begin
              state    <= ADDR_ACK;
              busy     <= 1'b1;
              rw       <= shift[0];
              pend_oe  <= 1'b1;
              hold_cnt <= HOLD_W'(SDA_HOLD_CLKS - 1);
            end else begin
              state <= WAIT_STOP;
            end
          end
          REG, WDATA: if (bit_cnt == 4'd8) begin
            bit_cnt  <= '0;
            state    <= (state == REG) ? REG_ACK : WDATA_ACK;
            pend_oe  <= 1'b1;
            hold_cnt <= HOLD_W'(SDA_HOLD_CLKS - 1);
          end
          ADDR_ACK, RDATA_ACK: begin
            if (state == RDATA_ACK || rw == RW_READ) begin
              state   <= RDATA;
              shift   <= regs[ptr];
              pend_oe <= ~regs[ptr][7];
            end else begin
              state   <= REG;
              pend_oe <= 1'b0;
            end
            hold_cnt <= HOLD_W'(SDA_HOLD_CLKS - 1);
          end
          REG_ACK, WDATA_ACK: begin
            state    <= WDATA;
            pend_oe  <= 1'b0;
            hold_cnt <= HOLD_W'(SDA_HOLD_CLKS - 1);
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              state   <= RDATA_ACK;
              pend_oe <= 1'b0;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              pend_oe <= ~shift[6];
            end
            hold_cnt <= HOLD_W'(SDA_HOLD_CLKS - 1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C master driving the target against a behavioural register-file model;
// write events are scoreboarded by a monitor, read bytes and ACKs are checked by the master.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  localparam int         NREGS = 16;
  localparam int         PTR_W = 4;
  localparam int         Q     = 12;
  localparam logic [6:0] DEV   = 7'h50;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             m_scl = 1'b1;
  logic             m_sda = 1'b1;
  logic             sda_line;
  logic             sda_oe, busy, wr_valid, rd_nack;
  logic [PTR_W-1:0] wr_reg;
  logic [PTR_W-1:0] host_raddr = '0;
  logic [7:0]       wr_data, host_rdata;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_regfile #(.DEV_ADDR(DEV), .NREGS(NREGS), .SDA_HOLD_CLKS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (m_scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_valid   (wr_valid),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .rd_nack    (rd_nack),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int d;} wr_ev_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_regs [NREGS];
  int         model_ptr = 0;
  wr_ev_t     exp_wr_q[$];
  int         exp_nack = 0;
  bit         oe_seen  = 1'b0;
  logic [7:0] tx_buf [8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clockBit(input logic b, output logic s);
    m_sda = b;
    waitQ();
    m_scl = 1'b1;
    waitQ();
    s = sda_line;
    waitQ();
    m_scl = 1'b0;
    waitQ();
  endtask

  task automatic i2cStart();
    if (!m_scl) begin
      m_sda = 1'b1;
      waitQ();
      m_scl = 1'b1;
      waitQ();
    end
    m_sda = 1'b0;
    waitQ();
    m_scl = 1'b0;
    waitQ();
  endtask

  task automatic i2cStop();
    m_sda = 1'b0;
    waitQ();
    m_scl = 1'b1;
    waitQ();
    m_sda = 1'b1;
    waitQ();
    waitQ();
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, ack);
  endtask

  task automatic recvByte(input logic ack_bit, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      b[i] = s;
    end
    clockBit(ack_bit, s);
  endtask

  task automatic compareRegs();
    for (int i = 0; i < NREGS; i++) begin
      host_raddr = PTR_W'(i);
      #1;
      checkOutput($sformatf("host_rdata_%0d", i), int'(host_rdata), int'(model_regs[i]));
    end
  endtask

  // One full transaction; writes take their data from tx_buf.
  task automatic applyStimulus(input bit is_read, input bit set_ptr, input logic [7:0] reg_byte, input int n);
    logic       a;
    logic [7:0] got, exp;
    i2cStart();
    if (!is_read || set_ptr) begin
      sendByte({DEV, RW_WRITE}, a);
      checkOutput("addr_w_ack", int'(a), int'(I2C_ACK));
      checkOutput("busy_after_addr", int'(busy), 1);
      sendByte(reg_byte, a);
      checkOutput("reg_ack", int'(a), int'(I2C_ACK));
      model_ptr = int'(reg_byte) % NREGS;
    end
    if (!is_read) begin
      for (int i = 0; i < n; i++) begin
        exp_wr_q.push_back('{model_ptr, int'(tx_buf[i])});
        model_regs[model_ptr] = tx_buf[i];
        model_ptr = (model_ptr + 1) % NREGS;
        sendByte(tx_buf[i], a);
        checkOutput("data_ack", int'(a), int'(I2C_ACK));
      end
    end else begin
      if (set_ptr) i2cStart();
      sendByte({DEV, RW_READ}, a);
      checkOutput("addr_r_ack", int'(a), int'(I2C_ACK));
      checkOutput("busy_after_addr_r", int'(busy), 1);
      for (int i = 0; i < n; i++) begin
        exp = model_regs[model_ptr];
        model_ptr = (model_ptr + 1) % NREGS;
        if (i == n - 1) exp_nack++;
        recvByte((i == n - 1) ? I2C_NACK : I2C_ACK, got);
        checkOutput("rd_byte", int'(got), int'(exp));
      end
      checkOutput("busy_after_nack", int'(busy), 0);
    end
    i2cStop();
    checkOutput("busy_after_stop", int'(busy), 0);
  endtask

  // Scoreboard monitor: every DUT write/NACK pulse must match a queued expectation.
  always @(negedge clk) begin
    wr_ev_t ev;
    if (sda_oe) oe_seen = 1'b1;
    if (!reset && wr_valid) begin
      checkOutput("wr_expected", int'(exp_wr_q.size() > 0), 1);
      if (exp_wr_q.size() > 0) begin
        ev = exp_wr_q.pop_front();
        checkOutput("wr_reg", int'(wr_reg), ev.r);
        checkOutput("wr_data", int'(wr_data), ev.d);
      end
    end
    if (!reset && rd_nack) begin
      checkOutput("rd_nack_expected", int'(exp_nack > 0), 1);
      if (exp_nack > 0) exp_nack--;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic a;
    logic s;
    bit   rd, sp;
    int   n;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;

    repeat (5) @(negedge clk);
    checkOutput("rst_sda_oe", int'(sda_oe), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_wr_valid", int'(wr_valid), 0);
    checkOutput("rst_rd_nack", int'(rd_nack), 0);
    checkOutput("rst_wr_reg", int'(wr_reg), 0);
    checkOutput("rst_wr_data", int'(wr_data), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    compareRegs();

    $display("[TB] write 5A,C3 at reg 3");
    tx_buf[0] = 8'h5A;
    tx_buf[1] = 8'hC3;
    applyStimulus(1'b0, 1'b1, 8'h03, 2);
    compareRegs();

    $display("[TB] read two bytes from reg 3, then one from the persisted pointer");
    applyStimulus(1'b1, 1'b1, 8'h03, 2);
    applyStimulus(1'b1, 1'b0, 8'h00, 1);

    $display("[TB] foreign address 0x51");
    oe_seen = 1'b0;
    i2cStart();
    sendByte(8'hA2, a);
    checkOutput("foreign_addr_nack", int'(a), int'(I2C_NACK));
    for (int i = 0; i < 2; i++) begin
      sendByte(8'($urandom), a);
      checkOutput("foreign_data_nack", int'(a), int'(I2C_NACK));
    end
    checkOutput("foreign_busy", int'(busy), 0);
    i2cStop();
    checkOutput("foreign_oe_seen", int'(oe_seen), 0);
    compareRegs();

    $display("[TB] pointer wrap at reg 15");
    tx_buf[0] = 8'h11;
    tx_buf[1] = 8'h22;
    applyStimulus(1'b0, 1'b1, 8'h0F, 2);
    compareRegs();
    applyStimulus(1'b1, 1'b0, 8'h00, 1);

    $display("[TB] STOP inside a data byte, then write 77 to reg 2");
    i2cStart();
    sendByte({DEV, RW_WRITE}, a);
    checkOutput("partial_addr_ack", int'(a), int'(I2C_ACK));
    sendByte(8'h02, a);
    checkOutput("partial_reg_ack", int'(a), int'(I2C_ACK));
    model_ptr = 2;
    for (int i = 0; i < 4; i++) clockBit(1'b1, s);
    i2cStop();
    tx_buf[0] = 8'h77;
    applyStimulus(1'b0, 1'b1, 8'h02, 1);
    compareRegs();

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      rd = 1'($urandom_range(0, 1));
      sp = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      n  = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      applyStimulus(rd, sp, 8'($urandom), n);
    end
    compareRegs();
    checkOutput("wr_pending", exp_wr_q.size(), 0);
    checkOutput("nack_pending", exp_nack, 0);

    $display("[TB] reset while driving a read bit");
    tx_buf[0] = 8'h3C;
    applyStimulus(1'b0, 1'b1, 8'h06, 1);
    i2cStart();
    sendByte({DEV, RW_WRITE}, a);
    sendByte(8'h06, a);
    i2cStart();
    sendByte({DEV, RW_READ}, a);
    checkOutput("rst_read_addr_ack", int'(a), int'(I2C_ACK));
    for (int i = 0; i < 40 && !sda_oe; i++) @(negedge clk);
    checkOutput("oe_before_reset", int'(sda_oe), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("oe_after_reset", int'(sda_oe), 0);
    checkOutput("busy_after_reset", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    m_sda = 1'b1;
    waitQ();
    m_scl = 1'b1;
    waitQ();
    compareRegs();
    applyStimulus(1'b1, 1'b0, 8'h00, 1);
    checkOutput("wr_pending_end", exp_wr_q.size(), 0);
    checkOutput("nack_pending_end", exp_nack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
